// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code read-side controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_POP  = 1'b1
  } state_t;

endpackage

// File: rtl/ps2_key_ctrl.sv
// Pops the ps2_keyboard FIFO one byte per two cycles, folds E0/F0 prefixes
// into single key events, and tracks the held key and distinct press count.
//
// state   | meaning
// IDLE    | waiting for kb_ready; accepts and decodes the head byte
// POP     | kb_nextdata_n low; FIFO advances at the end of this cycle
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int          CNT_W       = 8,
  parameter logic [15:0] PFX_TIMEOUT = 16'd50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_flag
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic        ext_p;
  logic        brk_p;
  logic [15:0] pfx_cnt;
  logic        accept;
  logic        same_key;

  assign accept   = (state == ST_IDLE) && kb_ready;
  assign same_key = (kb_data == held_code) && (ext_p == held_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ext_p         <= 1'b0;
      brk_p         <= 1'b0;
      pfx_cnt       <= '0;
      kb_nextdata_n <= 1'b1;
      key_valid     <= 1'b0;
      key_code      <= '0;
      key_ext       <= 1'b0;
      key_break     <= 1'b0;
      key_held      <= 1'b0;
      held_code     <= '0;
      held_ext      <= 1'b0;
      press_count   <= '0;
      ovf_flag      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (kb_overflow) ovf_flag <= 1'b1;

      case (state)
        ST_IDLE: begin
          kb_nextdata_n <= 1'b1;
          if (kb_ready) begin
            state         <= ST_POP;
            kb_nextdata_n <= 1'b0;
            if (kb_data == PS2_EXT) begin
              ext_p <= 1'b1;
            end else if (kb_data == PS2_BRK) begin
              brk_p <= 1'b1;
            end else begin
              key_valid <= 1'b1;
              key_code  <= kb_data;
              key_ext   <= ext_p;
              key_break <= brk_p;
              ext_p     <= 1'b0;
              brk_p     <= 1'b0;
              if (!brk_p) begin
                // A make matching the held key is typematic repeat, not a new press.
                if (!key_held || !same_key) begin
                  key_held    <= 1'b1;
                  held_code   <= kb_data;
                  held_ext    <= ext_p;
                  press_count <= press_count + CNT_ONE;
                end
              end else if (same_key) begin
                key_held  <= 1'b0;
                held_code <= '0;
                held_ext  <= 1'b0;
              end
            end
          end
        end
        ST_POP: begin
          state         <= ST_IDLE;
          kb_nextdata_n <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          kb_nextdata_n <= 1'b1;
        end
      endcase

      // Stale prefixes are dropped so a lost make byte cannot taint the next key.
      if (accept) begin
        pfx_cnt <= '0;
      end else if (ext_p || brk_p) begin
        if (pfx_cnt == PFX_TIMEOUT - 16'd1) begin
          ext_p   <= 1'b0;
          brk_p   <= 1'b0;
          pfx_cnt <= '0;
        end else begin
          pfx_cnt <= pfx_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized and directed bench for ps2_key_ctrl against a keystroke-level model.
module tb_ps2_key_ctrl;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n, key_valid, key_ext, key_break, key_held, held_ext, ovf_flag;
  logic [7:0] key_code, held_code, press_count;
  logic [30:0] obs;

  ps2_key_ctrl #(.CNT_W(8), .PFX_TIMEOUT(16'd64)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_held(key_held), .held_code(held_code),
    .held_ext(held_ext), .press_count(press_count), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  assign obs = {kb_nextdata_n, key_valid, key_code, key_ext, key_break,
                key_held, held_code, held_ext, press_count, ovf_flag};

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int vectors = 0;
  int miscompares = 0;

  // Keystroke-level reference state
  bit       m_ext, m_brk, m_valid, m_kext, m_kbrk, m_held, m_hext, m_ovf;
  bit [7:0] m_code, m_hcode, m_cnt;
  int       m_last;

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_valid = 0; m_kext = 0; m_kbrk = 0;
    m_held = 0; m_hext = 0; m_ovf = 0; m_code = 0; m_hcode = 0; m_cnt = 0;
    m_last = 0;
  endfunction

  function automatic void model_accept(input bit [7:0] b, input int now);
    if ((m_ext || m_brk) && (now - m_last) > T) begin
      m_ext = 0;
      m_brk = 0;
    end
    m_last  = now;
    m_valid = 0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      m_valid = 1;
      m_code = b; m_kext = m_ext; m_kbrk = m_brk;
      if (!m_kbrk) begin
        if (!m_held || b != m_hcode || m_kext != m_hext) begin
          m_held = 1; m_hcode = b; m_hext = m_kext; m_cnt = m_cnt + 8'd1;
        end
      end else if (m_held && b == m_hcode && m_kext == m_hext) begin
        m_held = 0; m_hcode = 0; m_hext = 0;
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic logic [30:0] exp_vec(input bit in_pop);
    return {~in_pop, in_pop & m_valid, m_code, m_kext, m_kbrk,
            m_held, m_hcode, m_hext, m_cnt, m_ovf};
  endfunction

  // Leaves the bench at the negedge just after the accept edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      kb_ready = 1'b0;
      repeat (gap) @(negedge clk);
    end
    kb_data  = b;
    kb_ready = 1'b1;
    @(negedge clk);
    model_accept(b, edge_no);
  endtask

  task automatic finish_pop();
    @(negedge clk);
    kb_ready = 1'b0;
  endtask

  task automatic run_seq(input string name, input logic [7:0] bytes[$], input int gaps[$]);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], gaps[i]);
      vectors++;
      if (obs !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL %s accept[%0d] byte %h: got %h expected %h", name, i, bytes[i], obs, exp_vec(1));
      end
      finish_pop();
      vectors++;
      if (obs !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL %s pop[%0d] byte %h: got %h expected %h", name, i, bytes[i], obs, exp_vec(0));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; kb_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    vectors++;
    if (obs !== 31'h4000_0000) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", obs, 31'h4000_0000);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== exp_vec(0)) begin
      miscompares++;
      $display("FAIL idle_no_pop: got %h expected %h", obs, exp_vec(0));
    end
  endtask

  task automatic test_make_break();
    run_seq("make_break", '{8'h1C, 8'hF0, 8'h1C}, '{0, 0, 0});
    vectors++;
    if (press_count !== 8'd1 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL make_break_final: got count %0d held %b expected count 1 held 0", press_count, key_held);
    end
  endtask

  task automatic test_typematic();
    run_seq("typematic", '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, '{1, 0, 2, 0, 0});
    vectors++;
    if (press_count !== 8'd2 || key_held !== 1'b0) begin
      miscompares++;
      $display("FAIL typematic_final: got count %0d held %b expected count 2 held 0", press_count, key_held);
    end
  endtask

  task automatic test_extended();
    run_seq("extended", '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, '{0, 0, 0, 0, 0});
    run_seq("ext_plain_brk", '{8'hE0, 8'hE0, 8'h75, 8'hF0, 8'h75}, '{0, 0, 0, 0, 0});
    vectors++;
    if (key_held !== 1'b1 || held_code !== 8'h75 || held_ext !== 1'b1) begin
      miscompares++;
      $display("FAIL plain_brk_keeps_held: got held %b code %h ext %b expected 1 75 1", key_held, held_code, held_ext);
    end
    run_seq("f0_e0_order", '{8'hF0, 8'hE0, 8'h75}, '{0, 0, 0});
    vectors++;
    if (key_held !== 1'b0 || key_ext !== 1'b1 || key_break !== 1'b1) begin
      miscompares++;
      $display("FAIL f0_e0_break: got held %b ext %b brk %b expected 0 1 1", key_held, key_ext, key_break);
    end
  endtask

  task automatic test_timeout();
    // gap T-2 puts the next accept exactly T edges after the prefix: still pending.
    run_seq("timeout_edge", '{8'hE0, 8'h1C}, '{0, T - 2});
    vectors++;
    if (key_ext !== 1'b1) begin
      miscompares++;
      $display("FAIL prefix_kept_at_limit: got ext %b expected 1", key_ext);
    end
    run_seq("timeout_over", '{8'hE0, 8'h32, 8'hF0, 8'h32}, '{0, T - 1, 0, T + 5});
    vectors++;
    if (key_ext !== 1'b0 || key_break !== 1'b0 || press_count !== m_cnt) begin
      miscompares++;
      $display("FAIL prefix_expired: got ext %b brk %b expected 0 0", key_ext, key_break);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes[$];
    int         gaps[$];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      bytes.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
      gaps.push_back(0);
    end
    run_seq("wrap", bytes, gaps);
    vectors++;
    if (press_count !== 8'd0) begin
      miscompares++;
      $display("FAIL press_wrap: got %0d expected 0", press_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    int         gaps[$];
    int         r;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: bytes.push_back(8'hE0);
        1: bytes.push_back(8'hF0);
        2, 3: bytes.push_back(8'h1C);
        4: bytes.push_back(8'h32);
        5: bytes.push_back(8'h75);
        6: bytes.push_back(8'h6B);
        default: bytes.push_back(8'($urandom_range(1, 8'hDF)));
      endcase
      r = $urandom_range(0, 19);
      if (r < 12) gaps.push_back(0);
      else if (r < 18) gaps.push_back($urandom_range(1, 3));
      else gaps.push_back(T - 4 + $urandom_range(0, 5));
    end
    run_seq("random", bytes, gaps);
  endtask

  task automatic test_rst_during_pop();
    send_byte(8'h1C, 0);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    vectors++;
    if (obs !== 31'h4000_0000) begin
      miscompares++;
      $display("FAIL reset_in_pop: got %h expected %h", obs, 31'h4000_0000);
    end
    rst = 1'b0;
    @(negedge clk);
    model_accept(8'h1C, edge_no);
    vectors++;
    if (obs !== exp_vec(1)) begin
      miscompares++;
      $display("FAIL reread_after_reset: got %h expected %h", obs, exp_vec(1));
    end
    finish_pop();
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    m_ovf = 1;
    repeat (5) @(negedge clk);
    vectors++;
    if (ovf_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got %b expected 1", ovf_flag);
    end
    run_seq("decode_after_ovf", '{8'hE0, 8'h6B}, '{0, 0});
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_timeout();
    test_random();
    test_wrap();
    test_rst_during_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
